// File: rtl/lock_pkg.sv
// lock_pkg: shared constants and types for the c432 key loader.
//   KEY_W   - committed key width (drives p1..p36, key[0] = p1)
//   CHUNK_W - stream chunk width
//   NCHUNK  - data beats per frame (checksum beat follows)
//   CNT_W   - beat counter width, wide enough to count NCHUNK
package lock_pkg;

  localparam int unsigned KEY_W   = 36;
  localparam int unsigned CHUNK_W = 4;
  localparam int unsigned NCHUNK  = KEY_W / CHUNK_W;
  localparam int unsigned CNT_W   = $clog2(NCHUNK + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    CHK  = 2'd2
  } state_e;

endpackage

// File: rtl/key_shadow_reg.sv
// key_shadow_reg: chunk-indexed shadow of the incoming key plus running XOR.
//   clk, rst_n  - clock, async active-low reset
//   load_i      - store data_i into chunk idx_i and fold it into the XOR
//   first_i     - with load_i: restart the XOR from this chunk
//   idx_i       - chunk index (0 = LSB chunk)
//   data_i      - chunk payload
//   shadow_o    - assembled (unverified) key
//   acc_o       - XOR of data chunks loaded since the last first_i
module key_shadow_reg
  import lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               first_i,
  input  logic [CNT_W-1:0]   idx_i,
  input  logic [CHUNK_W-1:0] data_i,
  output logic [KEY_W-1:0]   shadow_o,
  output logic [CHUNK_W-1:0] acc_o
);

  logic [KEY_W-1:0]   shadow_q;
  logic [CHUNK_W-1:0] acc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      acc_q    <= '0;
    end else if (load_i) begin
      for (int unsigned i = 0; i < NCHUNK; i++) begin
        if (idx_i == CNT_W'(i)) shadow_q[i*CHUNK_W +: CHUNK_W] <= data_i;
      end
      acc_q <= (first_i ? '0 : acc_q) ^ data_i;
    end
  end

  assign shadow_o = shadow_q;
  assign acc_o    = acc_q;

endmodule

// File: rtl/lock_key_loader.sv
// lock_key_loader: framed serial key loader with XOR checksum and atomic
// commit of the unlock key for the MUX-locked c432 core.
//   clk, rst_n - clock, async active-low reset
//   s_valid/s_data/s_last/s_ready - chunk stream (s_last marks checksum beat)
//   key_clr    - synchronous wipe of the committed key, aborts any frame
//   key        - committed key (only ever written with a verified frame)
//   key_valid  - key holds a verified value
//   done/err   - one-cycle commit / reject pulses
//   busy       - FSM not in IDLE
module lock_key_loader
  import lock_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  input  logic [CHUNK_W-1:0] s_data,
  input  logic               s_last,
  output logic               s_ready,
  input  logic               key_clr,
  output logic [KEY_W-1:0]   key,
  output logic               key_valid,
  output logic               done,
  output logic               err,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               bad_q, bad_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               key_valid_q, key_valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               accept;
  logic               sh_load;
  logic               sh_first;
  logic [KEY_W-1:0]   shadow;
  logic [CHUNK_W-1:0] acc;

  // s_ready is a function of registered state only.
  assign s_ready = (state_q != CHK);
  assign accept  = s_valid && s_ready && !key_clr;

  key_shadow_reg u_shadow (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (sh_load),
    .first_i  (sh_first),
    .idx_i    (cnt_q),
    .data_i   (s_data),
    .shadow_o (shadow),
    .acc_o    (acc)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    key_d       = key_q;
    key_valid_d = key_valid_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    sh_load     = 1'b0;
    sh_first    = 1'b0;

    if (key_clr) begin
      state_d     = IDLE;
      cnt_d       = '0;
      bad_d       = 1'b0;
      key_d       = '0;
      key_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            sh_load  = 1'b1;
            sh_first = 1'b1;
            cnt_d    = CNT_W'(1);
            // s_last on beat 0 is a framing error: go straight to CHK flagged bad.
            bad_d    = s_last;
            state_d  = s_last ? CHK : RECV;
          end
        end
        RECV: begin
          if (accept) begin
            if (cnt_q == CNT_W'(NCHUNK)) begin
              // Checksum beat: acc already holds the XOR of all data beats.
              bad_d   = !s_last || (s_data != acc);
              state_d = CHK;
            end else begin
              sh_load = 1'b1;
              cnt_d   = cnt_q + CNT_W'(1);
              if (s_last) begin
                bad_d   = 1'b1;
                state_d = CHK;
              end
            end
          end
        end
        CHK: begin
          if (bad_q) begin
            err_d = 1'b1;
          end else begin
            key_d       = shadow;
            key_valid_d = 1'b1;
            done_d      = 1'b1;
          end
          cnt_d   = '0;
          bad_d   = 1'b0;
          state_d = IDLE;
        end
        default: begin
          cnt_d   = '0;
          bad_d   = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bad_q       <= 1'b0;
      key_q       <= '0;
      key_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bad_q       <= bad_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign key       = key_q;
  assign key_valid = key_valid_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule
